// File: rtl/result_collector.sv
// DTEngine return path: buffers core and downstream result lines, sums them per lane, routes to PCIe or SL3.
// Optional build macro RESULT_SATURATE_EN: lane sums saturate instead of wrapping.

module result_collector_fifo #(
    parameter int WIDTH = 512,
    parameter int AW    = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
endmodule

module result_collector #(
    parameter int DATA_WIDTH      = 512,
    parameter int LANE_WIDTH      = 32,
    parameter int FIFO_DEPTH_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_core,
    input  logic                  host_node,
    input  logic                  last_node,
    input  logic [15:0]           num_result_lines_minus_one,
    input  logic [DATA_WIDTH-1:0] core_result,
    input  logic                  core_result_valid,
    output logic                  core_result_ready,
    input  logic [DATA_WIDTH-1:0] sl3_result,
    input  logic                  sl3_result_valid,
    output logic                  sl3_result_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  pcie_output_valid,
    input  logic                  pcie_output_ready,
    output logic                  sl3_output_valid,
    input  logic                  sl3_output_ready,
    output logic                  collector_empty,
    output logic [15:0]           lines_sent
);
    localparam int LANES = DATA_WIDTH / LANE_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic                  cmb;
    logic                  core_full;
    logic                  core_empty;
    logic                  sl3_full;
    logic                  sl3_empty;
    logic [DATA_WIDTH-1:0] core_head;
    logic [DATA_WIDTH-1:0] sl3_head;
    logic [DATA_WIDTH-1:0] sum_line;
    logic                  load;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_hs;
    logic                  at_last;
    logic [15:0]           line_cnt;

    assign cmb               = ~last_node;
    assign core_result_ready = ~core_full;
    assign sl3_result_ready  = ~sl3_full;

    result_collector_fifo #(.WIDTH(DATA_WIDTH), .AW(FIFO_DEPTH_BITS)) core_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (core_result),
        .wr_en   (core_result_valid & ~core_full),
        .rd_en   (load),
        .rd_data (core_head),
        .full    (core_full),
        .empty   (core_empty)
    );

    result_collector_fifo #(.WIDTH(DATA_WIDTH), .AW(FIFO_DEPTH_BITS)) sl3_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (sl3_result),
        .wr_en   (sl3_result_valid & ~sl3_full),
        .rd_en   (load & cmb),
        .rd_data (sl3_head),
        .full    (sl3_full),
        .empty   (sl3_empty)
    );

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_WIDTH-1:0] a;
        logic [LANE_WIDTH-1:0] b;
        logic [LANE_WIDTH-1:0] s;
        assign a = core_head[i*LANE_WIDTH +: LANE_WIDTH];
        assign b = sl3_head[i*LANE_WIDTH +: LANE_WIDTH];
`ifdef RESULT_SATURATE_EN
        logic [LANE_WIDTH:0] wide;
        assign wide = {a[LANE_WIDTH-1], a} + {b[LANE_WIDTH-1], b};
        // Sign bits disagree only on signed overflow.
        always_comb begin
            s = wide[LANE_WIDTH-1:0];
            if (wide[LANE_WIDTH] != wide[LANE_WIDTH-1])
                s = wide[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
                                     : {1'b0, {(LANE_WIDTH-1){1'b1}}};
        end
`else
        assign s = a + b;
`endif
        assign sum_line[i*LANE_WIDTH +: LANE_WIDTH] = s;
    end

    assign at_last   = (line_cnt == num_result_lines_minus_one);
    assign out_ready = host_node ? pcie_output_ready : sl3_output_ready;
    assign out_hs    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_core) state_next = RUN;
            RUN:     if (!start_core && out_hs && at_last) state_next = DONE;
            DONE:    if (start_core) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // The last line of a job does not pull the next job's first line in behind it.
    always_comb begin
        load = 1'b0;
        if (state == RUN && (!out_valid || (out_hs && !at_last)))
            load = cmb ? (!core_empty && !sl3_empty) : !core_empty;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= cmb ? sum_line : core_head;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_cnt   <= '0;
            lines_sent <= '0;
        end else if (start_core) begin
            line_cnt   <= '0;
            lines_sent <= '0;
        end else if (out_hs) begin
            line_cnt   <= at_last ? '0 : line_cnt + 16'd1;
            lines_sent <= lines_sent + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) collector_empty <= 1'b0;
        else        collector_empty <= core_empty & sl3_empty & ~out_valid;
    end

    assign out_last          = out_valid & at_last;
    assign pcie_output_valid = out_valid & host_node;
    assign sl3_output_valid  = out_valid & ~host_node;
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: routing, lane sums, backpressure, start and reset corners.
// Lane overflow expectations follow RESULT_SATURATE_EN when it is defined.

module tb_result_collector;
    localparam int DW    = 512;
    localparam int LANES = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_core;
    logic          host_node;
    logic          last_node;
    logic [15:0]   num_result_lines_minus_one;
    logic [DW-1:0] core_result;
    logic          core_result_valid;
    logic          core_result_ready;
    logic [DW-1:0] sl3_result;
    logic          sl3_result_valid;
    logic          sl3_result_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          pcie_output_valid;
    logic          pcie_output_ready;
    logic          sl3_output_valid;
    logic          sl3_output_ready;
    logic          collector_empty;
    logic [15:0]   lines_sent;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    result_collector dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .start_core                 (start_core),
        .host_node                  (host_node),
        .last_node                  (last_node),
        .num_result_lines_minus_one (num_result_lines_minus_one),
        .core_result                (core_result),
        .core_result_valid          (core_result_valid),
        .core_result_ready          (core_result_ready),
        .sl3_result                 (sl3_result),
        .sl3_result_valid           (sl3_result_valid),
        .sl3_result_ready           (sl3_result_ready),
        .out_data                   (out_data),
        .out_last                   (out_last),
        .pcie_output_valid          (pcie_output_valid),
        .pcie_output_ready          (pcie_output_ready),
        .sl3_output_valid           (sl3_output_valid),
        .sl3_output_ready           (sl3_output_ready),
        .collector_empty            (collector_empty),
        .lines_sent                 (lines_sent)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] core;
        logic [DW-1:0] sl3;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [DW-1:0] rep(input logic [31:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [DW-1:0] line(input int i);
        return rep(32'(i) + 32'h0000_1000);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start_core = 1'b0;
        core_result_valid = 1'b0;
        sl3_result_valid = 1'b0;
        core_result = '0;
        sl3_result = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start_core = 1'b1;
        tick();
        start_core = 1'b0;
    endtask

    task automatic push_core(input logic [DW-1:0] d);
        core_result = d;
        core_result_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (core_result_ready) begin
                tick();
                core_result_valid = 1'b0;
                return;
            end
            tick();
        end
        core_result_valid = 1'b0;
        check("push_core_timeout", 1'b0, 1'b1);
    endtask

    task automatic push_sl3(input logic [DW-1:0] d);
        sl3_result = d;
        sl3_result_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            if (sl3_result_ready) begin
                tick();
                sl3_result_valid = 1'b0;
                return;
            end
            tick();
        end
        sl3_result_valid = 1'b0;
        check("push_sl3_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_sl3_out(input string name);
        for (int t = 0; t < 20; t++) begin
            if (sl3_output_valid) return;
            tick();
        end
        check({name, "_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        logic [DW-1:0] got [4];
        logic [3:0]    got_last;
        logic [DW-1:0] first;
        logic [DW-1:0] pc;
        logic [DW-1:0] ps;
        logic [DW-1:0] pe;
        int            k;
        int            acc;
        int            err;
        int            last_err;
        bit            seen;
        bit            sl3_rdy_low;

        host_node = 1'b1;
        last_node = 1'b1;
        num_result_lines_minus_one = 16'd3;
        pcie_output_ready = 1'b1;
        sl3_output_ready = 1'b1;

        // Reset values, sampled while rst_n is still low.
        rst_n = 1'b0;
        start_core = 1'b0;
        core_result_valid = 1'b0;
        sl3_result_valid = 1'b0;
        core_result = '0;
        sl3_result = '0;
        tick();
        tick();
        check("rst_out_data", out_data, '0);
        check("rst_valids", {pcie_output_valid, sl3_output_valid, out_last}, 3'b000);
        check("rst_lines_sent", lines_sent, 16'd0);
        check("rst_empty", collector_empty, 1'b0);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_empty", collector_empty, 1'b1);

        // Host, single node, four-line job.
        pulse_start();
        k = 0;
        got_last = '0;
        seen = 1'b0;
        sl3_rdy_low = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) push_core(line(i));
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    if (sl3_output_valid) seen = 1'b1;
                    if (!sl3_result_ready) sl3_rdy_low = 1'b1;
                    if (pcie_output_valid && k < 4) begin
                        got[k] = out_data;
                        got_last[k] = out_last;
                        k++;
                    end
                    tick();
                end
            end
        join
        check("t1_count", 32'(k), 32'd4);
        for (int i = 0; i < 4; i++) check("t1_data", got[i], line(i));
        check("t1_last", got_last, 4'b1000);
        check("t1_lines_sent", lines_sent, 16'd4);
        check("t1_no_sl3_out", seen, 1'b0);
        check("t1_sl3_rdy_high", sl3_rdy_low, 1'b0);
        push_core(line(9));
        for (int t = 0; t < 8; t++) tick();
        check("t1_done_holds", pcie_output_valid, 1'b0);
        check("t1_done_cnt", lines_sent, 16'd4);

        // Non-host combine mode.
        do_reset();
        host_node = 1'b0;
        last_node = 1'b0;
        num_result_lines_minus_one = 16'd1000;
        pulse_start();
        push_core(rep(32'd5));
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (sl3_output_valid || pcie_output_valid) seen = 1'b1;
            tick();
        end
        check("t2_wait_for_sl3", seen, 1'b0);
        push_sl3(rep(32'd7));
        wait_sl3_out("t2_first");
        check("t2_sum_12", out_data, rep(32'd12));
        check("t2_pcie_quiet", pcie_output_valid, 1'b0);
        tick();

        vecs[0] = '{"lanes_5_7", rep(32'd5), rep(32'd7), rep(32'd12)};
`ifdef RESULT_SATURATE_EN
        vecs[1] = '{"pos_ovf", rep(32'h7FFF_FFFF), rep(32'd1), rep(32'h7FFF_FFFF)};
        vecs[2] = '{"neg_ovf", rep(32'h8000_0000), rep(32'hFFFF_FFFF), rep(32'h8000_0000)};
`else
        vecs[1] = '{"pos_ovf", rep(32'h7FFF_FFFF), rep(32'd1), rep(32'h8000_0000)};
        vecs[2] = '{"neg_ovf", rep(32'h8000_0000), rep(32'hFFFF_FFFF), rep(32'h7FFF_FFFF)};
`endif
        vecs[3] = '{"m1_p1", rep(32'hFFFF_FFFF), rep(32'd1), rep(32'd0)};
        vecs[4] = '{"mixed_sign", rep(32'd100), rep(32'hFFFF_FFE2), rep(32'd70)};
        for (int i = 0; i < LANES; i++) begin
            pc[i*32 +: 32] = 32'(i) * 32'h1000 + 32'd1;
            ps[i*32 +: 32] = 32'(i);
            pe[i*32 +: 32] = 32'(i) * 32'h1001 + 32'd1;
        end
        vecs[5] = '{"per_lane", pc, ps, pe};

        for (int v = 0; v < 6; v++) begin
            core_result = vecs[v].core;
            sl3_result = vecs[v].sl3;
            core_result_valid = 1'b1;
            sl3_result_valid = 1'b1;
            tick();
            core_result_valid = 1'b0;
            sl3_result_valid = 1'b0;
            wait_sl3_out(vecs[v].name);
            check(vecs[v].name, out_data, vecs[v].exp);
            tick();
        end
        check("t2_lines_sent", lines_sent, 16'd7);

        // Output stalled 600 cycles while core streams.
        do_reset();
        host_node = 1'b1;
        last_node = 1'b1;
        num_result_lines_minus_one = 16'd512;
        pcie_output_ready = 1'b0;
        pulse_start();
        acc = 0;
        err = 0;
        seen = 1'b0;
        first = '0;
        for (int c = 0; c < 600; c++) begin
            core_result = line(acc);
            core_result_valid = 1'b1;
            if (core_result_ready) acc++;
            tick();
            if (pcie_output_valid) begin
                if (!seen) begin
                    first = out_data;
                    seen = 1'b1;
                end else if (out_data !== first) begin
                    err++;
                end
            end
        end
        core_result_valid = 1'b0;
        // 512 lines fill the FIFO, one more sits in the output register.
        check("t3_accepted", 32'(acc), 32'd513);
        check("t3_ready_low", core_result_ready, 1'b0);
        check("t3_head", first, line(0));
        check("t3_stable", 32'(err), 32'd0);
        pcie_output_ready = 1'b1;
        k = 0;
        err = 0;
        last_err = 0;
        for (int t = 0; t < 700 && k < 513; t++) begin
            if (pcie_output_valid) begin
                if (out_data !== line(k)) err++;
                if (out_last !== (k == 512)) last_err++;
                k++;
            end
            tick();
        end
        check("t3_drained", 32'(k), 32'd513);
        check("t3_order", 32'(err), 32'd0);
        check("t3_last", 32'(last_err), 32'd0);
        check("t3_lines_sent", lines_sent, 16'd513);

        // Lines before start, one-line jobs.
        do_reset();
        num_result_lines_minus_one = 16'd0;
        push_core(line(64));
        push_core(line(65));
        for (int t = 0; t < 4; t++) tick();
        check("t4_idle_no_out", pcie_output_valid, 1'b0);
        check("t4_buffered", collector_empty, 1'b0);
        pulse_start();
        check("t4_pop_cycle", pcie_output_valid, 1'b0);
        tick();
        check("t4_out_valid", pcie_output_valid, 1'b1);
        check("t4_out_data", out_data, line(64));
        check("t4_out_last", out_last, 1'b1);
        for (int t = 0; t < 4; t++) tick();
        check("t4_done_stop", pcie_output_valid, 1'b0);
        check("t4_lines_sent", lines_sent, 16'd1);

        // Reset in the middle of a stalled job.
        do_reset();
        num_result_lines_minus_one = 16'd100;
        pcie_output_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) push_core(line(i));
        tick();
        tick();
        check("t5_busy", {collector_empty, pcie_output_valid}, 2'b01);
        rst_n = 1'b0;
        tick();
        check("t5_rst_data", out_data, '0);
        check("t5_rst_flags", {pcie_output_valid, out_last, collector_empty}, 3'b000);
        check("t5_rst_cnt", lines_sent, 16'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("t5_empty", collector_empty, 1'b1);
        pcie_output_ready = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (pcie_output_valid) seen = 1'b1;
            tick();
        end
        check("t5_flushed", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
